// File: rtl/ptmch_reg_array_if.sv
// Avalon-MM slave bus bundle for the page-match register array.
// The interconnect drives the master side; the register block takes the slave side.
interface ptmch_reg_array_if;
    logic        REG_BEGINTRANSFER;
    logic [15:0] REG_ADDRESS;
    logic        REG_CS;
    logic        REG_READ;
    logic        REG_WRITE;
    logic [31:0] REG_READDATA;
    logic [31:0] REG_WRITEDATA;
    logic        REG_WAITREQUEST;

    modport master (
        output REG_BEGINTRANSFER,
        output REG_ADDRESS,
        output REG_CS,
        output REG_READ,
        output REG_WRITE,
        output REG_WRITEDATA,
        input  REG_READDATA,
        input  REG_WAITREQUEST
    );

    modport slave (
        input  REG_BEGINTRANSFER,
        input  REG_ADDRESS,
        input  REG_CS,
        input  REG_READ,
        input  REG_WRITE,
        input  REG_WRITEDATA,
        output REG_READDATA,
        output REG_WAITREQUEST
    );
endinterface

// File: rtl/ptmch_reg_array.sv
// NUM_CH page-window event counters with snapshot, clear, sticky overflow and a
// maskable interrupt, exposed as Avalon-MM registers.
module ptmch_reg_array #(
    parameter int          NUM_CH = 5,
    parameter int          ADDR_W = 24,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] RTL_ID = 32'h5A5A_0100
) (
    input  logic                     CLK100M,
    input  logic                     RESET,
    input  logic [NUM_CH-1:0]        CH_EVENT,
    input  logic [NUM_CH*ADDR_W-1:0] CH_PAGE_ADDR,
    output logic [NUM_CH*ADDR_W-1:0] CH_LOW_ADDR,
    output logic [NUM_CH*ADDR_W-1:0] CH_HIGH_ADDR,
    output logic [NUM_CH-1:0]        CH_MATCH,
    output logic                     IRQ,
    ptmch_reg_array_if.slave         reg_bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        acc;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] addr;
    logic [31:0] wdata;

    assign acc   = reg_bus.REG_BEGINTRANSFER & reg_bus.REG_CS;
    assign wr_en = acc & reg_bus.REG_WRITE;
    assign rd_en = acc & reg_bus.REG_READ;
    assign addr  = reg_bus.REG_ADDRESS;
    assign wdata = reg_bus.REG_WRITEDATA;

    assign reg_bus.REG_WAITREQUEST = acc;

    logic wr_ctrl;
    logic wr_ch_en;
    logic wr_ovf;
    logic wr_irq_en;
    logic snap_pulse;
    logic clr_all;

    assign wr_ctrl    = wr_en && (addr == 16'h0004);
    assign wr_ch_en   = wr_en && (addr == 16'h0008);
    assign wr_ovf     = wr_en && (addr == 16'h000C);
    assign wr_irq_en  = wr_en && (addr == 16'h0010);
    assign snap_pulse = wr_ctrl & wdata[1];
    assign clr_all    = wr_ctrl & wdata[2];

    logic              gen_en_q,  gen_en_d;
    logic [NUM_CH-1:0] ch_en_q,   ch_en_d;
    logic [NUM_CH-1:0] ovf_q,     ovf_d;
    logic [NUM_CH-1:0] irq_en_q,  irq_en_d;
    logic [NUM_CH-1:0] match_q,   match_d;
    logic              irq_q,     irq_d;
    logic [31:0]       rdata_q,   rdata_d;

    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] ch_sel;
    logic [31:0]       ch_rdata [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [ADDR_W-1:0] page;
        logic [ADDR_W-1:0] low_q,  low_d;
        logic [ADDR_W-1:0] high_q, high_d;
        logic [CNT_W-1:0]  live_q, live_d;
        logic [CNT_W-1:0]  snap_q, snap_d;
        logic              in_win;
        logic              inc;
        logic              wr_low;
        logic              wr_high;
        logic              wr_live;
        logic              clr;

        assign page   = CH_PAGE_ADDR[gi*ADDR_W +: ADDR_W];
        // LOW > HIGH naturally yields an empty window here.
        assign in_win = (low_q <= page) && (page <= high_q);
        assign inc    = CH_EVENT[gi] & gen_en_q & ch_en_q[gi] & in_win;

        assign ch_sel[gi] = (addr[15:8] == 8'h01) && (addr[7:4] == 4'(gi))
                            && (addr[1:0] == 2'b00);
        assign wr_low  = wr_en & ch_sel[gi] & (addr[3:2] == 2'd1);
        assign wr_high = wr_en & ch_sel[gi] & (addr[3:2] == 2'd2);
        assign wr_live = wr_en & ch_sel[gi] & (addr[3:2] == 2'd3);
        assign clr     = clr_all | wr_live;

        assign ovf_set[gi] = inc & (live_q == CNT_MAX);
        assign match_d[gi] = CH_EVENT[gi] & in_win;

        always_comb begin
            low_d  = low_q;
            high_d = high_q;
            snap_d = snap_q;
            live_d = live_q;
            if (wr_low)
                low_d = wdata[ADDR_W-1:0];
            if (wr_high)
                high_d = wdata[ADDR_W-1:0];
            // Snapshot takes the value before this edge's clear or increment.
            if (snap_pulse)
                snap_d = live_q;
            if (clr)
                live_d = '0;
            else if (inc && (live_q != CNT_MAX))
                live_d = live_q + CNT_W'(1);
        end

        always_ff @(posedge CLK100M) begin
            if (RESET) begin
                low_q  <= '0;
                high_q <= '1;
                live_q <= '0;
                snap_q <= '0;
            end else begin
                low_q  <= low_d;
                high_q <= high_d;
                live_q <= live_d;
                snap_q <= snap_d;
            end
        end

        assign ch_rdata[gi] = (addr[3:2] == 2'd0) ? 32'(snap_q) :
                              (addr[3:2] == 2'd1) ? 32'(low_q)  :
                              (addr[3:2] == 2'd2) ? 32'(high_q) :
                                                    32'(live_q);

        assign CH_LOW_ADDR[gi*ADDR_W +: ADDR_W]  = low_q;
        assign CH_HIGH_ADDR[gi*ADDR_W +: ADDR_W] = high_q;
    end

    always_comb begin
        gen_en_d = gen_en_q;
        ch_en_d  = ch_en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        if (wr_ctrl)
            gen_en_d = wdata[0];
        if (wr_ch_en)
            ch_en_d = wdata[NUM_CH-1:0];
        if (wr_irq_en)
            irq_en_d = wdata[NUM_CH-1:0];
        if (wr_ovf)
            ovf_d = ovf_d & ~wdata[NUM_CH-1:0];
        // A fresh overflow outranks a same-cycle write-1-to-clear.
        ovf_d = ovf_d | ovf_set;
        irq_d = |(ovf_q & irq_en_q);
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (addr)
                16'h0000: rdata_d = RTL_ID;
                16'h0004: rdata_d = {31'b0, gen_en_q};
                16'h0008: rdata_d = 32'(ch_en_q);
                16'h000C: rdata_d = 32'(ovf_q);
                16'h0010: rdata_d = 32'(irq_en_q);
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_sel[i])
                            rdata_d = ch_rdata[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK100M) begin
        if (RESET) begin
            gen_en_q <= 1'b0;
            ch_en_q  <= '1;
            ovf_q    <= '0;
            irq_en_q <= '0;
            match_q  <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            gen_en_q <= gen_en_d;
            ch_en_q  <= ch_en_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            match_q  <= match_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign CH_MATCH             = match_q;
    assign IRQ                  = irq_q;
    assign reg_bus.REG_READDATA = rdata_q;

endmodule

// File: tb/tb_ptmch_reg_array.sv
// Directed plus randomized bench for ptmch_reg_array against a behavioural
// register/counter model; every comparison is an immediate assertion.
module tb_ptmch_reg_array;
    localparam int          NUM_CH = 5;
    localparam int          ADDR_W = 24;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RTL_ID = 32'h5A5A_0100;
    localparam int unsigned CMAX   = (1 << CNT_W) - 1;
    localparam int unsigned AMAX   = (1 << ADDR_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_event;
    logic [NUM_CH*ADDR_W-1:0] ch_page;
    logic [NUM_CH*ADDR_W-1:0] ch_low;
    logic [NUM_CH*ADDR_W-1:0] ch_high;
    logic [NUM_CH-1:0]        ch_match;
    logic                     irq;

    ptmch_reg_array_if bus ();

    ptmch_reg_array #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RTL_ID(RTL_ID)
    ) dut (
        .CLK100M     (clk),
        .RESET       (rst),
        .CH_EVENT    (ch_event),
        .CH_PAGE_ADDR(ch_page),
        .CH_LOW_ADDR (ch_low),
        .CH_HIGH_ADDR(ch_high),
        .CH_MATCH    (ch_match),
        .IRQ         (irq),
        .reg_bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int match2_cnt;

    // Behavioural model state
    bit                m_gen;
    bit [NUM_CH-1:0]   m_chen, m_ovf, m_irqen;
    bit                m_irq;
    int unsigned       m_low  [NUM_CH];
    int unsigned       m_high [NUM_CH];
    int unsigned       m_live [NUM_CH];
    int unsigned       m_snap [NUM_CH];
    int unsigned       page   [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gen   = 1'b0;
        m_chen  = '1;
        m_ovf   = '0;
        m_irqen = '0;
        m_irq   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_low[i]  = 0;
            m_high[i] = AMAX;
            m_live[i] = 0;
            m_snap[i] = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [15:0] a);
        int ai;
        int ch;
        int off;
        ai = int'(a);
        if (ai % 4 != 0) return 32'h0;
        case (ai)
            'h00: return RTL_ID;
            'h04: return {31'b0, m_gen};
            'h08: return 32'(m_chen);
            'h0C: return 32'(m_ovf);
            'h10: return 32'(m_irqen);
            default: ;
        endcase
        if (ai >= 256 && ai < 256 + NUM_CH * 16) begin
            ch  = (ai - 256) / 16;
            off = ai % 16;
            case (off)
                0:       return m_snap[ch];
                4:       return m_low[ch];
                8:       return m_high[ch];
                default: return m_live[ch];
            endcase
        end
        return 32'h0;
    endfunction

    function automatic bit m_inwin(input int ch);
        return (m_low[ch] <= page[ch]) && (page[ch] <= m_high[ch]);
    endfunction

    task automatic model_edge(input bit acc, input bit wr, input logic [15:0] a,
                              input logic [31:0] wd, input logic [NUM_CH-1:0] ev);
        bit              w;
        bit              inc;
        bit              irq_next;
        bit [NUM_CH-1:0] set;
        w        = acc && wr;
        irq_next = |(m_ovf & m_irqen);
        set      = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            inc = ev[ch] && m_gen && m_chen[ch] && m_inwin(ch);
            if (inc && m_live[ch] == CMAX) set[ch] = 1'b1;
            if (w && a == 16'h0004 && wd[1]) m_snap[ch] = m_live[ch];
            if ((w && a == 16'h0004 && wd[2]) || (w && a == 16'(256 + ch * 16 + 12)))
                m_live[ch] = 0;
            else if (inc && m_live[ch] < CMAX)
                m_live[ch] = m_live[ch] + 1;
        end
        if (w) begin
            case (a)
                16'h0004: m_gen   = wd[0];
                16'h0008: m_chen  = wd[NUM_CH-1:0];
                16'h000C: m_ovf   = m_ovf & ~wd[NUM_CH-1:0];
                16'h0010: m_irqen = wd[NUM_CH-1:0];
                default: begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (a == 16'(256 + ch * 16 + 4)) m_low[ch]  = wd & AMAX;
                        if (a == 16'(256 + ch * 16 + 8)) m_high[ch] = wd & AMAX;
                    end
                end
            endcase
        end
        m_ovf = m_ovf | set;
        m_irq = irq_next;
    endtask

    task automatic idle_bus();
        bus.REG_BEGINTRANSFER = 1'b0;
        bus.REG_CS            = 1'b0;
        bus.REG_READ          = 1'b0;
        bus.REG_WRITE         = 1'b0;
        bus.REG_ADDRESS       = 16'h0;
        bus.REG_WRITEDATA     = 32'h0;
        ch_event              = '0;
    endtask

    // One clock cycle: drive after a falling edge, check at the next falling edge.
    task automatic step(input bit bt, input bit cs, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [31:0] wd,
                        input logic [NUM_CH-1:0] ev);
        logic [31:0]     exp_rd;
        bit [NUM_CH-1:0] exp_match;
        bus.REG_BEGINTRANSFER = bt;
        bus.REG_CS            = cs;
        bus.REG_READ          = rd;
        bus.REG_WRITE         = wr;
        bus.REG_ADDRESS       = a;
        bus.REG_WRITEDATA     = wd;
        ch_event              = ev;
        for (int i = 0; i < NUM_CH; i++)
            ch_page[i*ADDR_W +: ADDR_W] = ADDR_W'(page[i]);
        #1;
        check("waitreq", 32'(bus.REG_WAITREQUEST), 32'(bt & cs));
        exp_rd = m_read(a);
        for (int i = 0; i < NUM_CH; i++) exp_match[i] = m_inwin(i);
        @(posedge clk);
        model_edge(bt & cs, wr, a, wd, ev);
        @(negedge clk);
        if (bt & cs & rd)
            check($sformatf("rdata@%04h", a), bus.REG_READDATA, exp_rd);
        for (int i = 0; i < NUM_CH; i++) begin
            if (ev[i]) check($sformatf("match%0d", i), 32'(ch_match[i]), 32'(exp_match[i]));
        end
        if (ev[2]) match2_cnt += int'(ch_match[2]);
        check("irq", 32'(irq), 32'(m_irq));
        idle_bus();
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, 1'b1, a, d, '0);
    endtask

    task automatic rd_reg(input logic [15:0] a);
        step(1'b1, 1'b1, 1'b1, 1'b0, a, 32'h0, '0);
    endtask

    task automatic ev_step(input logic [NUM_CH-1:0] ev);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, ev);
    endtask

    task automatic sweep_reads();
        for (int a = 0; a <= 'h14; a += 4) rd_reg(16'(a));
        for (int a = 'h100; a <= 'h15C; a += 4) rd_reg(16'(a));
    endtask

    task automatic check_windows();
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("low_out%0d", i), 32'(ch_low[i*ADDR_W +: ADDR_W]), m_low[i]);
            check($sformatf("high_out%0d", i), 32'(ch_high[i*ADDR_W +: ADDR_W]), m_high[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] ev;
        logic [15:0]       a;
        int                op;
        int                ch;

        rst = 1'b1;
        idle_bus();
        ch_page = '0;
        for (int i = 0; i < NUM_CH; i++) page[i] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", bus.REG_READDATA, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_match", 32'(ch_match), 32'h0);
        check("rst_waitreq", 32'(bus.REG_WAITREQUEST), 32'h0);
        check_windows();
        rst = 1'b0;

        // Identity and reset values
        rd_reg(16'h0000);
        rd_reg(16'h0108);
        rd_reg(16'h0008);
        rd_reg(16'h0004);

        // ch2 window 0x100..0x1FF
        wr_reg(16'h0004, 32'h1);
        wr_reg(16'h0124, 32'h100);
        wr_reg(16'h0128, 32'h1FF);
        match2_cnt = 0;
        page[2] = 'h0FF; ev_step(5'b00100);
        page[2] = 'h100; ev_step(5'b00100);
        page[2] = 'h1FF; ev_step(5'b00100);
        page[2] = 'h200; ev_step(5'b00100);
        check("match2_pulses", 32'(match2_cnt), 32'd2);
        rd_reg(16'h012C);

        // ch0 saturation, overflow, interrupt, set-beats-clear
        page[0] = 'h55;
        wr_reg(16'h0010, 32'h1);
        repeat (17) ev_step(5'b00001);
        rd_reg(16'h010C);
        rd_reg(16'h000C);
        ev_step('0);
        check("irq_sat", 32'(irq), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000C, 32'h1, 5'b00001);
        rd_reg(16'h000C);

        // ch1 snapshot + clear-all together with an event
        page[1] = 'h10;
        repeat (7) ev_step(5'b00010);
        rd_reg(16'h011C);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 32'h3, 5'b00010);
        rd_reg(16'h0110);
        rd_reg(16'h011C);

        // Out-of-range channel and non-access cycles
        rd_reg(16'h0150);
        wr_reg(16'h0150, 32'hFFFF_FFFF);
        wr_reg(16'h0154, 32'h1234);
        wr_reg(16'h0158, 32'h0);
        wr_reg(16'h015C, 32'h5);
        wr_reg(16'h0126, 32'h7);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0, '0);
        sweep_reads();

        // Empty window on ch3
        wr_reg(16'h0134, 32'h300);
        wr_reg(16'h0138, 32'h200);
        page[3] = 'h250;
        repeat (3) ev_step(5'b01000);
        rd_reg(16'h013C);
        check_windows();

        // Randomized traffic
        wr_reg(16'h0004, 32'h1);
        repeat (400) begin
            ev = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) page[i] = $urandom_range(0, 'h3FF);
            op = $urandom_range(0, 11);
            ch = $urandom_range(0, NUM_CH);
            case (op)
                0, 1, 2: begin
                    if ($urandom_range(0, 1) == 1)
                        a = 16'(256 + $urandom_range(0, NUM_CH) * 16 + $urandom_range(0, 3) * 4);
                    else
                        a = 16'($urandom_range(0, 'h16));
                    step(1'b1, 1'b1, 1'b1, 1'b0, a, 32'h0, ev);
                end
                3: step(1'b1, 1'b1, 1'b0, 1'b1, 16'(256 + ch * 16 + 4), $urandom_range(0, 'h3FF), ev);
                4: step(1'b1, 1'b1, 1'b0, 1'b1, 16'(256 + ch * 16 + 8), $urandom_range(0, 'h3FF), ev);
                5: step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 32'($urandom_range(0, 7)) | 32'h1, ev);
                6: step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0008, $urandom, ev);
                7: step(1'b1, 1'b1, 1'b0, 1'b1, 16'h000C, $urandom, ev);
                8: step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, $urandom, ev);
                9: step(1'b1, 1'b1, 1'b0, 1'b1, 16'(256 + ch * 16 + 12), $urandom, ev);
                default: ev_step(ev);
            endcase
        end
        sweep_reads();
        check_windows();

        // Reset arriving together with a read
        bus.REG_BEGINTRANSFER = 1'b1;
        bus.REG_CS            = 1'b1;
        bus.REG_READ          = 1'b1;
        bus.REG_ADDRESS       = 16'h0000;
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        check("rst_read_rdata", bus.REG_READDATA, 32'h0);
        check("rst_read_irq", 32'(irq), 32'h0);
        for (int i = 0; i < NUM_CH; i++) begin
            rd_reg(16'(256 + i * 16 + 12));
            rd_reg(16'(256 + i * 16));
        end
        rd_reg(16'h000C);
        check_windows();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ptmch_reg_array.md
Name: ptmch_reg_array

Overview:
- Parametrised successor to the fixed five-command page-match register block.
- NUM_CH identical channels, each with its own page-address window and its own internal saturating event counter. The counter increments only when the channel's page address falls inside the window.
- Adds snapshot, clear, sticky overflow status and a maskable interrupt.
- Sits between the SPI-NAND command monitor (per-channel event strobes and page addresses) and the Avalon-MM interconnect.

Parameters:
- NUM_CH, 5, number of channels; legal range 1..16.
- ADDR_W, 24, page-address width; legal range 1..32.
- CNT_W, 32, event-counter width; legal range 1..32.
- RTL_ID, 32'h5A5A_0100, value returned at offset 0x0000.

Ports:
- CLK100M  in  1  single system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CH_EVENT  in  NUM_CH  per-channel one-cycle event strobe.
- CH_PAGE_ADDR  in  NUM_CH*ADDR_W  page address per channel; channel i occupies bits [i*ADDR_W +: ADDR_W]; sampled in the same cycle as CH_EVENT.
- CH_LOW_ADDR  out  NUM_CH*ADDR_W  window low bound per channel, same packing.
- CH_HIGH_ADDR  out  NUM_CH*ADDR_W  window high bound per channel, same packing.
- CH_MATCH  out  NUM_CH  registered result of the window compare (LOW <= PAGE <= HIGH), one cycle after the address.
- IRQ  out  1  level interrupt, registered.
- REG_BEGINTRANSFER  in  1  Avalon begin-transfer.
- REG_ADDRESS  in  16  byte address.
- REG_CS  in  1  chip select.
- REG_READ  in  1  read.
- REG_WRITE  in  1  write.
- REG_READDATA  out  32  registered read data.
- REG_WRITEDATA  in  32  write data.
- REG_WAITREQUEST  out  1  combinational, = REG_BEGINTRANSFER & REG_CS.

Behaviour:
- Access strobe: acc = REG_BEGINTRANSFER & REG_CS. Write when acc & REG_WRITE; read when acc & REG_READ.
- Read data is registered and valid on the cycle after acc. Unmapped, misaligned, or channel index >= NUM_CH: reads return 0, writes are ignored.
- Register map, global:
  - 0x0000 ID (RO) = RTL_ID.
  - 0x0004 CTRL:
    - bit0 GEN_EN (RW).
    - bit1 SNAP (write-1 pulse, reads 0).
    - bit2 CLR_ALL (write-1 pulse, reads 0).
  - 0x0008 CH_EN[NUM_CH-1:0] (RW).
  - 0x000C OVF[NUM_CH-1:0] (sticky; write-1-to-clear).
  - 0x0010 IRQ_EN[NUM_CH-1:0] (RW).
- Register map, per channel i (base 0x0100 + i*0x10):
  - +0x0 SNAP_CNT (RO).
  - +0x4 LOW (RW, ADDR_W bits, zero-extended on read).
  - +0x8 HIGH (RW, same).
  - +0xC LIVE_CNT (RO; any write clears this channel's count).
- Reset values: all outputs and registers 0, except HIGH = all ones and CH_EN = all ones. REG_READDATA = 0, IRQ = 0, CH_MATCH = 0.
- Increment condition: inc_i = CH_EVENT[i] & GEN_EN & CH_EN[i] & (LOW_i <= CH_PAGE_ADDR_i) & (CH_PAGE_ADDR_i <= HIGH_i), using an unsigned compare. LIVE_CNT_i increments on the next edge.
- LOW > HIGH gives an empty window: no counting.
- Saturation: LIVE_CNT saturates at 2^CNT_W-1. inc_i while saturated sets OVF[i]; the count holds.
- SNAP copies every LIVE_CNT into SNAP_CNT on the same edge, using pre-increment values. An event in the same cycle lands in LIVE only.
- Precedence per channel:
  - Clear (CLR_ALL or LIVE_CNT write) beats a simultaneous inc: count = 0.
  - SNAP together with CLR_ALL captures the pre-clear values.
- OVF W1C in the same cycle as a new overflow: set wins.
- IRQ is registered: IRQ <= |(OVF & IRQ_EN), updating one cycle after OVF or IRQ_EN changes.
- A LOW/HIGH write takes effect for inc evaluation from the cycle after the write edge.
- RESET asserted mid-transfer: all state returns to reset values on that edge. A read pending at that point returns 0.

Test Plan:
- Reset then read 0x0000 → 0x5A5A_0100. Read ch0 +0x8 → 0x00FF_FFFF. Read 0x0008 → 0x1F (NUM_CH=5).
- GEN_EN=1, ch2 LOW=0x100, HIGH=0x1FF. Events at pages 0x0FF, 0x100, 0x1FF, 0x200 → ch2 LIVE_CNT=2, CH_MATCH[2] pulses twice.
- CNT_W=4: 17 in-window events on ch0 → LIVE_CNT=15, OVF=0x01. With IRQ_EN=0x01, IRQ=1. Write 0x000C=0x01 in the same cycle as an 18th event → OVF stays 1.
- ch1 LIVE=7, then CTRL=0x3 (SNAP+CLR_ALL) in the same cycle as a ch1 event → ch1 SNAP_CNT=7, LIVE_CNT=0.
- Read 0x0150 (ch5, NUM_CH=5) → 0. Write to it, then re-read all registers → unchanged. REG_WAITREQUEST high exactly on acc cycles.
- LOW=0x300 > HIGH=0x200 with events at 0x250 → no count. Assert RESET during a read → REG_READDATA=0 next cycle, all counters 0.
